apb_cmd_master: RTL

//  APB initiator for the SPI register block: turns single-beat register commands into APB

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_cmd_master.sv | 120 ++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB command master and its users:
//   - FSM state encoding of the APB initiator
//   - register map of the SPI controller's APB slave
//   - default bus widths
// ---------------------------------------------------------------------------
package apb_pkg;

  // Default APB widths for the SPI register block.
  localparam int APB_ADDR_W = 3;
  localparam int APB_DATA_W = 8;

  // APB initiator FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  // SPI controller register map.
  localparam logic [APB_ADDR_W-1:0] REG_CR1 = 3'd0;
  localparam logic [APB_ADDR_W-1:0] REG_CR2 = 3'd1;
  localparam logic [APB_ADDR_W-1:0] REG_BR  = 3'd2;
  localparam logic [APB_ADDR_W-1:0] REG_SR  = 3'd3;
  localparam logic [APB_ADDR_W-1:0] REG_DR  = 3'd5;

endpackage

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
// APB initiator for the SPI register block. Turns single-beat register
// commands into one APB transfer (SETUP then ACCESS), waits for pready and
// returns read data and error status. One transfer in flight at a time.
//
// Ports
//   pclk, preset_n           clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_write/addr/wdata     command payload, captured on accept
//   rsp_valid                one-cycle completion pulse, no backpressure
//   rsp_rdata / rsp_err      completion payload, held until next completion
//   psel penable pwrite paddr pwdata   APB request (all registered)
//   prdata pready pslverr    APB completion, only looked at in ACCESS
//   dbg_state                current FSM state (apb_pkg ST_* encoding)
//
// Handshake: a command is transferred on a rising edge where
// cmd_valid && cmd_ready. cmd_ready is high exactly in IDLE and is a pure
// decode of the state register; the command source may hold cmd_valid and
// change the payload freely while cmd_ready is low. rsp_valid has no ready:
// the consumer must take the response in the cycle it is asserted.
// ---------------------------------------------------------------------------
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT);
  // Last ACCESS cycle allowed to wait; reaching it with pready low ends the
  // transfer with an error, giving exactly TIMEOUT ACCESS cycles in total.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  assign cmd_ready = (state == ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            paddr    <= cmd_addr;
            pwrite   <= cmd_write;
            pwdata   <= cmd_wdata;
            psel     <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= pwrite ? '0 : prdata;
            state     <= ST_IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            // Slave never answered: abandon the transfer with an error.
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
